mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the flattened client-channel bus and the single
// main-memory bus seen by mem_bus_arbiter.
//   Channel side : ch_vis_signal, ch_vis_addr, ch_written_data, ch_data_type,
//                  ch_length (requests in); ch_data, ch_status (results out).
//                  Channel i occupies slice i of every ch_* vector.
//   Memory side  : mem_vis_signal, mem_vis_addr, mem_written_data,
//                  mem_data_type, mem_length (request out); mem_data,
//                  mem_status (response in).
//   grant_id     : channel currently owning memory.
// Modports: master = arbiter view, slave = clients + memory view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH         = 17,
  parameter int DATA_LEN           = 32,
  parameter int ENTRY_INDEX_SIZE   = 3,
  parameter int CHANNEL_NUM        = 4,
  parameter int CHANNEL_INDEX_SIZE = 2
) ();
  logic [2*CHANNEL_NUM-1:0]                    ch_vis_signal;
  logic [ADDR_WIDTH*CHANNEL_NUM-1:0]           ch_vis_addr;
  logic [DATA_LEN*CHANNEL_NUM-1:0]             ch_written_data;
  logic [3*CHANNEL_NUM-1:0]                    ch_data_type;
  logic [(ENTRY_INDEX_SIZE+1)*CHANNEL_NUM-1:0] ch_length;
  logic [DATA_LEN-1:0]                         ch_data;
  logic [2*CHANNEL_NUM-1:0]                    ch_status;

  logic [1:0]                                  mem_vis_signal;
  logic [ADDR_WIDTH-1:0]                       mem_vis_addr;
  logic [DATA_LEN-1:0]                         mem_written_data;
  logic [2:0]                                  mem_data_type;
  logic [ENTRY_INDEX_SIZE:0]                   mem_length;
  logic [DATA_LEN-1:0]                         mem_data;
  logic [1:0]                                  mem_status;

  logic [CHANNEL_INDEX_SIZE-1:0]               grant_id;

  modport master (
    input  ch_vis_signal, ch_vis_addr, ch_written_data, ch_data_type, ch_length,
    input  mem_data, mem_status,
    output ch_data, ch_status,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length,
    output grant_id
  );

  modport slave (
    output ch_vis_signal, ch_vis_addr, ch_written_data, ch_data_type, ch_length,
    output mem_data, mem_status,
    input  ch_data, ch_status,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length,
    input  grant_id
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: CHANNEL_NUM-way round-robin arbiter in front of main memory.
// One granted request at a time is forwarded to memory, held until memory
// reports FINISHED, and the result is returned to the owning channel with a
// one-cycle FINISHED status pulse. All outputs are registered.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_bus_arbiter_if.master (channel requests/status, memory
//          request/response, grant_id)
// Build option:
//   MEM_ARB_CH0_PRIORITY_EN - when defined, channel 0 wins every arbitration
//   it takes part in without moving rr_ptr; channels 1..N-1 rotate among
//   themselves. Undefined: plain round-robin over all channels.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH         = 17,
  parameter int DATA_LEN           = 32,
  parameter int ENTRY_INDEX_SIZE   = 3,
  parameter int CHANNEL_NUM        = 4,
  parameter int CHANNEL_INDEX_SIZE = 2
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  localparam logic [1:0] SIG_IDLE      = 2'b00;
  localparam logic [1:0] SIG_READ      = 2'b01;
  localparam logic [1:0] SIG_WRITE     = 2'b10;
  localparam logic [1:0] STAT_IDLE     = 2'b00;
  localparam logic [1:0] STAT_BUSY     = 2'b01;
  localparam logic [1:0] STAT_FINISHED = 2'b10;

  localparam int LEN_W = ENTRY_INDEX_SIZE + 1;
  localparam int CW    = CHANNEL_INDEX_SIZE + 1;

`ifdef MEM_ARB_CH0_PRIORITY_EN
  localparam bit CH0_PRIO = 1'b1;
`else
  localparam bit CH0_PRIO = 1'b0;
`endif

  logic [1:0]                    state;
  logic [CHANNEL_INDEX_SIZE-1:0] rr_ptr;

  logic [CHANNEL_NUM-1:0]        pending;
  logic                          found;
  logic [CHANNEL_INDEX_SIZE-1:0] winner;
  logic [CW-1:0]                 scan_sum;
  logic [CHANNEL_INDEX_SIZE-1:0] rr_next;

  logic [1:0]                    sel_sig;
  logic [ADDR_WIDTH-1:0]         sel_addr;
  logic [DATA_LEN-1:0]           sel_wdata;
  logic [2:0]                    sel_type;
  logic [LEN_W-1:0]              sel_len;

  logic [2*CHANNEL_NUM-1:0]      status_next;
  logic [CHANNEL_INDEX_SIZE-1:0] ci;
  logic                          mem_done;

  // Only READ and WRITE count as requests; reserved 11 behaves like IDLE.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      pending[i] = (bus.ch_vis_signal[2*i +: 2] == SIG_READ) ||
                   (bus.ch_vis_signal[2*i +: 2] == SIG_WRITE);
    end
  end

  // Scan from rr_ptr with wrap-around; first pending channel wins. In
  // priority mode channel 0 is decided up front and skipped by the scan.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    if (CH0_PRIO && pending[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
      scan_sum = {1'b0, rr_ptr} + CW'(k);
      if (scan_sum >= CW'(CHANNEL_NUM)) begin
        scan_sum = scan_sum - CW'(CHANNEL_NUM);
      end
      if (!found && pending[scan_sum[CHANNEL_INDEX_SIZE-1:0]] &&
          !(CH0_PRIO && scan_sum == '0)) begin
        found  = 1'b1;
        winner = scan_sum[CHANNEL_INDEX_SIZE-1:0];
      end
    end
  end

  always_comb begin
    if (winner == CHANNEL_INDEX_SIZE'(CHANNEL_NUM - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = winner + 1'b1;
    end
  end

  // Winner's request fields.
  always_comb begin
    sel_sig   = SIG_IDLE;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_type  = '0;
    sel_len   = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (CHANNEL_INDEX_SIZE'(i) == winner) begin
        sel_sig   = bus.ch_vis_signal[2*i +: 2];
        sel_addr  = bus.ch_vis_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_wdata = bus.ch_written_data[DATA_LEN*i +: DATA_LEN];
        sel_type  = bus.ch_data_type[3*i +: 3];
        sel_len   = bus.ch_length[LEN_W*i +: LEN_W];
      end
    end
  end

  assign mem_done = (state == ST_WAIT) && (bus.mem_status == STAT_FINISHED);

  // Status seen after the next edge: FINISHED for the owner entering RESPOND,
  // BUSY for the owner through WAIT (even if it dropped its request),
  // otherwise BUSY/IDLE from the live request.
  always_comb begin
    status_next = '0;
    ci          = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      ci = CHANNEL_INDEX_SIZE'(i);
      if (mem_done && ci == bus.grant_id) begin
        status_next[2*i +: 2] = STAT_FINISHED;
      end else if (state == ST_IDLE && found && ci == winner) begin
        status_next[2*i +: 2] = STAT_BUSY;
      end else if (state == ST_WAIT && ci == bus.grant_id) begin
        status_next[2*i +: 2] = STAT_BUSY;
      end else if (pending[i]) begin
        status_next[2*i +: 2] = STAT_BUSY;
      end else begin
        status_next[2*i +: 2] = STAT_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      bus.grant_id         <= '0;
      bus.mem_vis_signal   <= SIG_IDLE;
      bus.mem_vis_addr     <= '0;
      bus.mem_written_data <= '0;
      bus.mem_data_type    <= '0;
      bus.mem_length       <= '0;
      bus.ch_data          <= '0;
      bus.ch_status        <= '0;
    end else begin
      bus.ch_status <= status_next;
      case (state)
        ST_IDLE: begin
          if (found) begin
            bus.mem_vis_signal   <= sel_sig;
            bus.mem_vis_addr     <= sel_addr;
            bus.mem_written_data <= sel_wdata;
            bus.mem_data_type    <= sel_type;
            bus.mem_length       <= sel_len;
            bus.grant_id         <= winner;
            if (!(CH0_PRIO && winner == '0)) begin
              rr_ptr <= rr_next;
            end
            state <= ST_WAIT;
          end else begin
            bus.mem_vis_signal <= SIG_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_done) begin
            bus.ch_data        <= bus.mem_data;
            bus.mem_vis_signal <= SIG_IDLE;
            state              <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (4 channels, default widths).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_bus_arbiter_if #(
    .ADDR_WIDTH(17), .DATA_LEN(32), .ENTRY_INDEX_SIZE(3),
    .CHANNEL_NUM(4), .CHANNEL_INDEX_SIZE(2)
  ) bus ();

  mem_bus_arbiter #(
    .ADDR_WIDTH(17), .DATA_LEN(32), .ENTRY_INDEX_SIZE(3),
    .CHANNEL_NUM(4), .CHANNEL_INDEX_SIZE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ch_vis_signal   = '0;
    bus.ch_vis_addr     = '0;
    bus.ch_written_data = '0;
    bus.ch_data_type    = '0;
    bus.ch_length       = '0;
    bus.mem_data        = '0;
    bus.mem_status      = 2'b00;
  endtask

  task automatic set_req(input int ch, input logic [1:0] sig, input logic [16:0] addr);
    bus.ch_vis_signal[2*ch +: 2] = sig;
    bus.ch_vis_addr[17*ch +: 17] = addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".mem_vis_signal"}, 64'(bus.mem_vis_signal), 64'h0);
    check({tag, ".mem_vis_addr"}, 64'(bus.mem_vis_addr), 64'h0);
    check({tag, ".mem_written_data"}, 64'(bus.mem_written_data), 64'h0);
    check({tag, ".mem_data_type"}, 64'(bus.mem_data_type), 64'h0);
    check({tag, ".mem_length"}, 64'(bus.mem_length), 64'h0);
    check({tag, ".grant_id"}, 64'(bus.grant_id), 64'h0);
    check({tag, ".ch_data"}, 64'(bus.ch_data), 64'h0);
    check({tag, ".ch_status"}, 64'(bus.ch_status), 64'h0);
  endtask

`ifndef MEM_ARB_CH0_PRIORITY_EN
  logic [1:0]  fair_grant  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0]  fair_resp   [5] = '{8'h56, 8'h59, 8'h65, 8'h95, 8'h56};
  logic [16:0] fair_addr   [5] = '{17'h00100, 17'h00200, 17'h00300, 17'h00400, 17'h00100};
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single read on channel 1, memory answers after 3 WAIT cycles.
    set_req(1, 2'b01, 17'h00040);
    tick();
    check("rd.mem_vis_signal", 64'(bus.mem_vis_signal), 64'h1);
    check("rd.mem_vis_addr", 64'(bus.mem_vis_addr), 64'h40);
    check("rd.grant_id", 64'(bus.grant_id), 64'h1);
    check("rd.ch_status_busy", 64'(bus.ch_status), 64'h04);
    tick();
    tick();
    check("rd.held_signal", 64'(bus.mem_vis_signal), 64'h1);
    check("rd.held_status", 64'(bus.ch_status), 64'h04);
    bus.mem_status = 2'b10;
    bus.mem_data   = 32'hDEADBEEF;
    tick();
    check("rd.finished", 64'(bus.ch_status), 64'h08);
    check("rd.ch_data", 64'(bus.ch_data), 64'hDEADBEEF);
    check("rd.mem_released", 64'(bus.mem_vis_signal), 64'h0);
    bus.mem_status = 2'b00;
    set_req(1, 2'b00, 17'h0);
    tick();
    check("rd.pulse_one_cycle", 64'(bus.ch_status), 64'h00);
    tick();
    check("rd.no_regrant", 64'(bus.mem_vis_signal), 64'h0);

`ifndef MEM_ARB_CH0_PRIORITY_EN
    // All four channels read continuously: strict rotation with wrap 3 -> 0.
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 2'b01, 17'(17'h00100 * (c + 1)));
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("fair%0d.grant_id", t), 64'(bus.grant_id), 64'(fair_grant[t]));
      check($sformatf("fair%0d.addr", t), 64'(bus.mem_vis_addr), 64'(fair_addr[t]));
      check($sformatf("fair%0d.busy", t), 64'(bus.ch_status), 64'h55);
      bus.mem_status = 2'b10;
      bus.mem_data   = 32'(t + 32'hA0);
      tick();
      check($sformatf("fair%0d.resp", t), 64'(bus.ch_status), 64'(fair_resp[t]));
      check($sformatf("fair%0d.data", t), 64'(bus.ch_data), 64'(t + 32'hA0));
      bus.mem_status = 2'b00;
      tick();
      check($sformatf("fair%0d.idle_gap", t), 64'(bus.mem_vis_signal), 64'h0);
    end
`else
    // Channel 0 beats channel 2 until it drops, then channel 2 is granted.
    do_reset();
    set_req(0, 2'b01, 17'h00010);
    set_req(2, 2'b01, 17'h00030);
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("prio%0d.grant_id", t), 64'(bus.grant_id), 64'h0);
      check($sformatf("prio%0d.busy", t), 64'(bus.ch_status), 64'h11);
      bus.mem_status = 2'b10;
      tick();
      check($sformatf("prio%0d.resp", t), 64'(bus.ch_status), 64'h12);
      bus.mem_status = 2'b00;
      if (t == 2) set_req(0, 2'b00, 17'h0);
      tick();
    end
    tick();
    check("prio.ch2_grant", 64'(bus.grant_id), 64'h2);
    check("prio.ch2_addr", 64'(bus.mem_vis_addr), 64'h30);
    check("prio.ch2_busy", 64'(bus.ch_status), 64'h10);
`endif

    // Write on channel 3; fields stay put even when the client changes them.
    do_reset();
    set_req(3, 2'b10, 17'h1ABCD);
    bus.ch_written_data[96 +: 32] = 32'h12345678;
    bus.ch_data_type[9 +: 3]      = 3'b010;
    bus.ch_length[12 +: 4]        = 4'd8;
    tick();
    check("wr.mem_vis_signal", 64'(bus.mem_vis_signal), 64'h2);
    check("wr.grant_id", 64'(bus.grant_id), 64'h3);
    check("wr.addr", 64'(bus.mem_vis_addr), 64'h1ABCD);
    check("wr.data", 64'(bus.mem_written_data), 64'h12345678);
    check("wr.type", 64'(bus.mem_data_type), 64'h2);
    check("wr.length", 64'(bus.mem_length), 64'h8);
    check("wr.busy", 64'(bus.ch_status), 64'h40);
    set_req(3, 2'b01, 17'h00007);
    bus.ch_written_data[96 +: 32] = 32'hFFFFFFFF;
    bus.ch_data_type[9 +: 3]      = 3'b111;
    bus.ch_length[12 +: 4]        = 4'd1;
    tick();
    check("wr.held_signal", 64'(bus.mem_vis_signal), 64'h2);
    check("wr.held_addr", 64'(bus.mem_vis_addr), 64'h1ABCD);
    check("wr.held_data", 64'(bus.mem_written_data), 64'h12345678);
    check("wr.held_type", 64'(bus.mem_data_type), 64'h2);
    check("wr.held_length", 64'(bus.mem_length), 64'h8);
    check("wr.held_busy", 64'(bus.ch_status), 64'h40);
    bus.mem_status = 2'b10;
    tick();
    check("wr.finished", 64'(bus.ch_status), 64'h80);
    bus.mem_status = 2'b00;
    set_req(3, 2'b00, 17'h0);
    tick();

    // Reset one cycle into WAIT while memory reports FINISHED.
    do_reset();
    set_req(1, 2'b01, 17'h00123);
    tick();
    check("rstw.in_wait", 64'(bus.mem_vis_signal), 64'h1);
    rst            = 1'b1;
    bus.mem_status = 2'b10;
    bus.mem_data   = 32'hCAFEF00D;
    tick();
    check_reset_outputs("rstw");
    rst            = 1'b0;
    bus.mem_status = 2'b00;
    set_req(1, 2'b00, 17'h0);
    tick();
    check("rstw.no_finish", 64'(bus.ch_status), 64'h00);
    check("rstw.ch_data", 64'(bus.ch_data), 64'h0);
    tick();
    check("rstw.idle", 64'(bus.mem_vis_signal), 64'h0);

    // Reserved code on channel 2 is neither granted nor reported busy.
    do_reset();
    set_req(2, 2'b11, 17'h00055);
    tick();
    check("rsv.mem_vis_signal", 64'(bus.mem_vis_signal), 64'h0);
    check("rsv.ch_status", 64'(bus.ch_status), 64'h00);
    tick();
    check("rsv.still_idle", 64'(bus.mem_vis_signal), 64'h0);
    check("rsv.ch2_status", 64'(bus.ch_status[5:4]), 64'h0);
    check("rsv.grant_id", 64'(bus.grant_id), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
